// File: rtl/pc_unit.sv
// Fetch program-counter unit: holds the fetch PC and the EPC, selects the
// next PC (sequential, branch, jump, jump-register, exception entry, ERET)
// and buffers normal redirects that arrive while fetch is stalled.
module pc_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Stop,
    input  logic             BranchTaken,
    input  logic [15:0]      BranchOffset,
    input  logic [WIDTH-1:0] BranchBase,
    input  logic             Jump,
    input  logic [25:0]      JumpIndex,
    input  logic             JumpReg,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             ExcReq,
    input  logic [WIDTH-1:0] ExcPC,
    input  logic             Eret,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic [WIDTH-1:0] EPC,
    output logic             AdEL,
    output logic             RedirectPending
);

    // Vectors are given as 32-bit constants and zero-extended to WIDTH.
    localparam logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(32'd4);
    localparam logic [WIDTH-1:0] ZERO      = '0;

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] epc_r;
    logic [WIDTH-1:0] pend_r;
    logic             pend_valid_r;

    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] epc_next_s;
    logic [WIDTH-1:0] pend_next_s;
    logic             pend_valid_next_s;

    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] branch_tgt_s;
    logic [WIDTH-1:0] jump_tgt_s;
    logic [WIDTH-1:0] redirect_tgt_s;
    logic             redirect_s;

    assign pc_plus4_s   = pc_r + PC_STEP;
    // Branch offset is a word offset: sign-extend then scale by 4.
    assign branch_tgt_s = BranchBase + {{(WIDTH-18){BranchOffset[15]}}, BranchOffset, 2'b00};
    // J-format keeps the upper region bits of the delay-slot PC.
    assign jump_tgt_s   = {BranchBase[WIDTH-1:28], JumpIndex, 2'b00};
    assign redirect_s   = JumpReg | Jump | BranchTaken;

    // Select the normal redirect target; JR beats J beats a taken branch.
    always_comb begin
        redirect_tgt_s = branch_tgt_s;
        case ({JumpReg, Jump})
            2'b10, 2'b11: redirect_tgt_s = JumpTarget;
            2'b01:        redirect_tgt_s = jump_tgt_s;
            2'b00:        redirect_tgt_s = branch_tgt_s;
            default:      redirect_tgt_s = branch_tgt_s;
        endcase
    end

    // Next-state selection: exception and ERET ignore the stall; normal
    // redirects during a stall are parked in the pending register.
    always_comb begin
        pc_next_s         = pc_r;
        epc_next_s        = epc_r;
        pend_next_s       = pend_r;
        pend_valid_next_s = pend_valid_r;
        if (ExcReq) begin
            pc_next_s         = EXC_VEC;
            epc_next_s        = ExcPC;
            pend_next_s       = ZERO;
            pend_valid_next_s = 1'b0;
        end else if (Eret) begin
            pc_next_s         = epc_r;
            pend_next_s       = ZERO;
            pend_valid_next_s = 1'b0;
        end else if (redirect_s) begin
            if (Stop) begin
                pend_next_s       = redirect_tgt_s;
                pend_valid_next_s = 1'b1;
            end else begin
                pc_next_s         = redirect_tgt_s;
                pend_next_s       = ZERO;
                pend_valid_next_s = 1'b0;
            end
        end else if (!Stop) begin
            if (pend_valid_r) begin
                pc_next_s         = pend_r;
                pend_valid_next_s = 1'b0;
            end else begin
                pc_next_s = pc_plus4_s;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_r         <= RESET_VEC;
            epc_r        <= ZERO;
            pend_r       <= ZERO;
            pend_valid_r <= 1'b0;
        end else begin
            pc_r         <= pc_next_s;
            epc_r        <= epc_next_s;
            pend_r       <= pend_next_s;
            pend_valid_r <= pend_valid_next_s;
        end
    end

    assign PC              = pc_r;
    assign EPC             = epc_r;
    assign RedirectPending = pend_valid_r;
    assign PCPlus4         = pc_plus4_s;
    assign AdEL            = (pc_r[1:0] != 2'b00);

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised fetch program-counter unit for the pipelined MIPS core. It holds the fetch PC, selects the next PC, and holds an EPC register.
- Next-PC sources: sequential, branch, jump, jump-register, exception entry and ERET.
- Redirects that arrive while fetch is stalled are buffered and applied when the stall releases.
- Fetch-address misalignment is flagged for the exception logic.

Parameters:
- WIDTH, 32, PC/address width; legal range 32..64.
- RESET_VECTOR, 32'h0000_3000, PC value after reset (zero-extended to WIDTH).
- EXC_VECTOR, 32'h0000_4180, exception entry address (zero-extended to WIDTH).

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stop  in  1  fetch stall; holds PC for sequential advance and normal redirects.
- BranchTaken  in  1  conditional branch resolved taken this cycle.
- BranchOffset  in  16  branch immediate; sign-extended, then shifted left 2.
- BranchBase  in  WIDTH  PC+4 of the branch/jump instruction in ID.
- Jump  in  1  J/JAL redirect.
- JumpIndex  in  26  J-format instruction index.
- JumpReg  in  1  JR/JALR redirect.
- JumpTarget  in  WIDTH  register target for JumpReg.
- ExcReq  in  1  take exception.
- ExcPC  in  WIDTH  PC to save into EPC on ExcReq.
- Eret  in  1  return from exception.
- PC  out  WIDTH  current fetch PC.
- PCPlus4  out  WIDTH  PC+4, combinational, wraps mod 2^WIDTH.
- EPC  out  WIDTH  saved exception PC.
- AdEL  out  1  combinational; 1 when PC[1:0] != 0.
- RedirectPending  out  1  a buffered redirect is waiting for Stop to deassert.

Behaviour:
- Reset low (asynchronous): PC=RESET_VECTOR, EPC=0, pending target=0, RedirectPending=0. Reset dominates every other input.
- Target computation, all arithmetic mod 2^WIDTH:
  - branch target = BranchBase + (sext(BranchOffset)<<2).
  - jump target = {BranchBase[WIDTH-1:28], JumpIndex, 2'b00}.
  - jump-register target = JumpTarget, applied unmodified (no alignment forced).
- Priority per edge: ExcReq > Eret > JumpReg > Jump > BranchTaken > pending > sequential.
- ExcReq ignores Stop: PC<=EXC_VECTOR, EPC<=ExcPC, pending cleared, RedirectPending<=0.
- Eret (no ExcReq) ignores Stop: PC<=EPC (the pre-edge value), pending cleared.
- ExcReq and Eret in the same cycle: the exception is taken; Eret is dropped.
- Normal redirect (JumpReg/Jump/BranchTaken) with Stop=0: PC<=target next edge (1-cycle latency). Any pending entry is discarded.
- Normal redirect with Stop=1: PC holds; pending<=target; RedirectPending<=1. A newer redirect during the stall overwrites pending.
- Stop=0, no redirect, RedirectPending=1: PC<=pending; RedirectPending<=0.
- Stop=0, nothing pending: PC<=PCPlus4.
- Stop=1, no redirect: PC, pending and RedirectPending all hold.
- PC wraps to 0 from 2^WIDTH-4.
- AdEL is advisory only. PC is not altered; the exception logic decides whether to raise ExcReq.
- EPC changes only on ExcReq or reset.

Test Plan:
1. Reset low mid-run with PC=0x3010 -> PC=0x3000 and EPC=0 immediately, without waiting for a clock edge. Release reset, run 3 edges -> PC=0x300C, PCPlus4=0x3010.
2. Branch: BranchBase=0x3008, BranchOffset=16'hFFFE, BranchTaken=1, Stop=0 -> next PC=0x3000. Jump: BranchBase=0x3008, JumpIndex=26'h0000C40 -> next PC=0x3100.
3. Stall buffering: Stop=1, JumpReg=1 with JumpTarget=0x3400 -> PC holds, RedirectPending=1. Next cycle Stop=1, BranchTaken=1 with target 0x3200 -> pending overwritten. Stop drops -> PC=0x3200, RedirectPending=0.
4. Exception during stall: Stop=1, RedirectPending=1, ExcReq=1, ExcPC=0x3014 -> PC=0x4180, EPC=0x3014, RedirectPending=0. Then Eret=1 -> PC=0x3014.
5. ExcReq and Eret together with EPC=0x3020, ExcPC=0x3050 -> PC=0x4180, EPC=0x3050.
6. JumpReg with JumpTarget=0x3002 -> PC=0x3002 and AdEL=1. Separately, WIDTH=32 with PC=0xFFFFFFFC -> PCPlus4=0 and next PC=0 after a sequential edge.
